// File: rtl/reg_bank_shift.sv
// Bank of DEPTH words of W bits, moved as a whole by one opcode per cycle.
// Also keeps a saturating count of words shifted in since the last clear.
module reg_bank_shift #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic [W-1:0]                 d,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [W-1:0]                 rd_data,
  output logic [W-1:0]                 q_head,
  output logic [W-1:0]                 q_tail,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHU  = 3'b010;
  localparam logic [2:0] OP_SHD  = 3'b011;
  localparam logic [2:0] OP_ROU  = 3'b100;
  localparam logic [2:0] OP_ROD  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  logic [W-1:0]  r_q [DEPTH];
  logic [W-1:0]  r_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_inc;

  // Saturating increment shared by both shift directions.
  assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + CW'(1);

  always_comb begin
    r_d     = r_q;
    count_d = count_q;
    if (en) begin
      case (op)
        OP_HOLD: ;
        OP_LOAD: begin
          // Out-of-range addresses match no entry, so nothing is written.
          for (int i = 0; i < DEPTH; i++) begin
            if (int'(wr_addr) == i) r_d[i] = d;
          end
        end
        OP_SHU: begin
          r_d[0] = d;
          for (int i = 1; i < DEPTH; i++) r_d[i] = r_q[i-1];
          count_d = count_inc;
        end
        OP_SHD: begin
          r_d[DEPTH-1] = d;
          for (int i = 0; i < DEPTH-1; i++) r_d[i] = r_q[i+1];
          count_d = count_inc;
        end
        OP_ROU: begin
          r_d[0] = r_q[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) r_d[i] = r_q[i-1];
        end
        OP_ROD: begin
          r_d[DEPTH-1] = r_q[0];
          for (int i = 0; i < DEPTH-1; i++) r_d[i] = r_q[i+1];
        end
        OP_CLR: begin
          for (int i = 0; i < DEPTH; i++) r_d[i] = '0;
          count_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      count_q <= '0;
    end else begin
      r_q     <= r_d;
      count_q <= count_d;
    end
  end

  // Read port sees registered state only; unmatched addresses read zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(rd_addr) == i) rd_data = r_q[i];
    end
  end

  assign q_head = r_q[0];
  assign q_tail = r_q[DEPTH-1];
  assign count  = count_q;
  assign full   = (count_q == DEPTH_C);

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;

endmodule

// File: tb/tb_reg_bank_shift.sv
// Bench for reg_bank_shift: a DEPTH=4 bank for the main sequence and a
// DEPTH=6 bank for out-of-range addressing.
`timescale 1ns/1ps
module tb_reg_bank_shift;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHU  = 3'b010;
  localparam logic [2:0] OP_SHD  = 3'b011;
  localparam logic [2:0] OP_ROU  = 3'b100;
  localparam logic [2:0] OP_ROD  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- DUT A: W=4, DEPTH=4 ----------------
  logic       en;
  logic [2:0] op;
  logic [3:0] d;
  logic [1:0] wr_addr;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] q_head;
  logic [3:0] q_tail;
  logic [2:0] count;
  logic       full;

  reg_bank_shift #(.W(4), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .op(op), .d(d),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .q_head(q_head), .q_tail(q_tail), .count(count), .full(full)
  );

  // ---------------- DUT B: W=4, DEPTH=6 ----------------
  logic       en6;
  logic [2:0] op6;
  logic [3:0] d6;
  logic [2:0] wr_addr6;
  logic [2:0] rd_addr6;
  logic [3:0] rd_data6;
  logic [3:0] q_head6;
  logic [3:0] q_tail6;
  logic [2:0] count6;
  logic       full6;

  reg_bank_shift #(.W(4), .DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .en(en6), .op(op6), .d(d6),
    .wr_addr(wr_addr6), .rd_addr(rd_addr6), .rd_data(rd_data6),
    .q_head(q_head6), .q_tail(q_tail6), .count(count6), .full(full6)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pop_exp(input string tag, output logic [7:0] v);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got empty scoreboard expected an entry", tag);
      v = 8'hxx;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  // Expected bank state for the 4-deep DUT: entries, count, full.
  task automatic expect_bank(input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3,
                             input logic [2:0] cnt);
    exp_q.push_back({4'h0, e0});
    exp_q.push_back({4'h0, e1});
    exp_q.push_back({4'h0, e2});
    exp_q.push_back({4'h0, e3});
    exp_q.push_back({5'h0, cnt});
    exp_q.push_back({7'h0, cnt == 3'd4});
  endtask

  task automatic check_bank(input string tag);
    logic [7:0] e [4];
    logic [7:0] ec, ef;
    for (int i = 0; i < 4; i++) pop_exp(tag, e[i]);
    pop_exp(tag, ec);
    pop_exp(tag, ef);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("%s r%0d", tag, i), {4'h0, rd_data}, e[i]);
    end
    check({tag, " head"},  {4'h0, q_head}, e[0]);
    check({tag, " tail"},  {4'h0, q_tail}, e[3]);
    check({tag, " count"}, {5'h0, count},  ec);
    check({tag, " full"},  {7'h0, full},   ef);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic r, input logic e, input logic [2:0] o,
                       input logic [3:0] dv, input logic [1:0] wa);
    @(negedge clk);
    reset = r; en = e; op = o; d = dv; wr_addr = wa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reset = 1'b0; en = 1'b0; op = OP_HOLD;
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] o,
                      input logic [3:0] dv, input logic [1:0] wa);
    drive(r, e, o, dv, wa);
    tick();
  endtask

  task automatic step6(input logic e, input logic [2:0] o,
                       input logic [3:0] dv, input logic [2:0] wa);
    @(negedge clk);
    en6 = e; op6 = o; d6 = dv; wr_addr6 = wa;
    @(posedge clk);
    #1;
    en6 = 1'b0; op6 = OP_HOLD;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    reset = 1'b0; en = 1'b0; op = OP_HOLD; d = '0; wr_addr = '0; rd_addr = '0;
    en6 = 1'b0; op6 = OP_HOLD; d6 = '0; wr_addr6 = '0; rd_addr6 = '0;

    expect_bank(0, 0, 0, 0, 0);
    step(1, 0, OP_HOLD, 0, 0);
    check_bank("reset");

    // Fill by shifting up, then saturate.
    expect_bank(1, 0, 0, 0, 1); step(0, 1, OP_SHU, 4'h1, 0); check_bank("shu1");
    expect_bank(2, 1, 0, 0, 2); step(0, 1, OP_SHU, 4'h2, 0); check_bank("shu2");
    expect_bank(3, 2, 1, 0, 3); step(0, 1, OP_SHU, 4'h3, 0); check_bank("shu3");
    expect_bank(4, 3, 2, 1, 4); step(0, 1, OP_SHU, 4'h4, 0); check_bank("shu4");
    expect_bank(5, 4, 3, 2, 4); step(0, 1, OP_SHU, 4'h5, 0); check_bank("shu5_sat");
    expect_bank(6, 5, 4, 3, 4); step(0, 1, OP_SHU, 4'h6, 0); check_bank("shu6_sat");

    // Rotations and enable gating.
    expect_bank(3, 6, 5, 4, 4); step(0, 1, OP_ROU, 4'hF, 0); check_bank("rou");
    expect_bank(6, 5, 4, 3, 4); step(0, 1, OP_ROD, 4'hF, 0); check_bank("rod");
    for (int k = 0; k < 3; k++) begin
      expect_bank(6, 5, 4, 3, 4); step(0, 0, OP_ROU, 4'hF, 0); check_bank("en0_rou");
    end
    expect_bank(6, 5, 4, 3, 4); step(0, 1, OP_RSV, 4'hF, 1); check_bank("reserved");
    expect_bank(6, 5, 4, 3, 4); step(0, 1, OP_HOLD, 4'hF, 1); check_bank("hold");

    // Load with same-cycle read of the target: old value until the edge.
    exp_q.push_back(8'h04);
    drive(0, 1, OP_LOAD, 4'hA, 2'd2);
    rd_addr = 2'd2;
    #1;
    pop_exp("load_old", v);
    check("load_old", {4'h0, rd_data}, v);
    tick();
    exp_q.push_back(8'h0A);
    rd_addr = 2'd2;
    #1;
    pop_exp("load_new", v);
    check("load_new", {4'h0, rd_data}, v);
    expect_bank(6, 5, 4'hA, 3, 4); check_bank("load");

    expect_bank(5, 4'hA, 3, 9, 4); step(0, 1, OP_SHD, 4'h9, 0); check_bank("shd");
    expect_bank(0, 0, 0, 0, 0); step(0, 1, OP_CLR, 4'h9, 0); check_bank("clr");
    expect_bank(0, 0, 0, 2, 1); step(0, 1, OP_SHD, 4'h2, 0); check_bank("shd_cnt");
    expect_bank(7, 0, 0, 0, 2); step(0, 1, OP_SHU, 4'h7, 0); check_bank("shu7");
    expect_bank(7, 0, 0, 0, 2); step(0, 0, OP_CLR, 4'h0, 0); check_bank("clr_en0");

    // Reset beats a concurrent shift; F must not appear.
    expect_bank(0, 0, 0, 0, 0); step(1, 1, OP_SHU, 4'hF, 0); check_bank("rst_vs_shu");

    // Reset in the middle of a rotation run; the run does not resume.
    expect_bank(4'hB, 0, 0, 0, 1); step(0, 1, OP_SHU, 4'hB, 0); check_bank("pre_rot");
    expect_bank(0, 4'hB, 0, 0, 1); step(0, 1, OP_ROU, 0, 0);    check_bank("rot1");
    expect_bank(0, 0, 0, 0, 0);    step(1, 1, OP_ROU, 0, 0);    check_bank("rot_rst");
    expect_bank(0, 0, 0, 0, 0);    step(0, 0, OP_ROU, 0, 0);    check_bank("rot_after");

    // DEPTH=6: valid load, then out-of-range load and read.
    step6(1, OP_LOAD, 4'hC, 3'd5);
    exp_q.push_back(8'h0C);
    rd_addr6 = 3'd5; #1;
    pop_exp("d6_load5", v); check("d6_load5", {4'h0, rd_data6}, v);
    step6(1, OP_LOAD, 4'h5, 3'd7);
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 5) ? 8'h0C : 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_addr6 = 3'(i); #1;
      pop_exp("d6_oob", v);
      check($sformatf("d6_oob rd%0d", i), {4'h0, rd_data6}, v);
    end
    exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
    pop_exp("d6_tail", v);  check("d6_tail",  {4'h0, q_tail6}, v);
    pop_exp("d6_count", v); check("d6_count", {5'h0, count6},  v);
    check("d6_full", {7'h0, full6}, 8'h00);
    check("d6_head", {4'h0, q_head6}, 8'h00);

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_shift.md
Name: reg_bank_shift

Overview:
- Parametrised successor to the single N-bit enabled register.
- Holds DEPTH words of W bits. The whole bank moves under one opcode per cycle: hold, addressed load, shift up/down, rotate up/down, or clear.
- Tracks a saturating fill count. Provides head, tail and random-access read outputs.
- Used as a generic delay line, sample window or small register file in datapath exercises.

Parameters:
- W, 4, word width in bits (>=1)
- DEPTH, 8, number of words (>=2, need not be a power of 2)
- Derived localparams (not overridable):
  - AW = $clog2(DEPTH), address width
  - CW = $clog2(DEPTH+1), count width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  operation enable; 0 forces hold
- op  in  3  opcode, see Behaviour
- d  in  W  data in (load/shift source)
- wr_addr  in  AW  target entry for LOAD
- rd_addr  in  AW  read-port address
- rd_data  out  W  combinational read of entry rd_addr
- q_head  out  W  entry 0
- q_tail  out  W  entry DEPTH-1
- count  out  CW  words shifted in since last clear/reset, saturating
- full  out  1  count == DEPTH

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset has priority over en/op.
  - On reset: all entries r[0..DEPTH-1] = 0, count = 0.
  - Outputs after the reset edge: q_head = q_tail = 0, count = 0, full = 0, rd_data = 0.
- Storage and outputs
  - State: array r[i] plus count register.
  - All outputs are derived from registered state only; no combinational path from d or op to any output.
  - rd_data depends on rd_addr combinationally.
- Enable
  - en = 0: every register holds, whatever op is.
- Opcodes when en = 1 (effects visible the cycle after the edge, latency 1):
  - 000 HOLD: no change.
  - 001 LOAD: r[wr_addr] <= d; other entries and count unchanged. wr_addr >= DEPTH: no write.
  - 010 SHU (shift up): r[0] <= d, r[i] <= r[i-1] for i >= 1. Old r[DEPTH-1] is discarded. count <= min(count+1, DEPTH).
  - 011 SHD (shift down): r[DEPTH-1] <= d, r[i] <= r[i+1] for i < DEPTH-1. Old r[0] is discarded. count <= min(count+1, DEPTH).
  - 100 ROU (rotate up): r[0] <= r[DEPTH-1], r[i] <= r[i-1]. count unchanged. d ignored.
  - 101 ROD (rotate down): r[DEPTH-1] <= r[0], r[i] <= r[i+1]. count unchanged.
  - 110 CLR: all entries 0, count 0 (same state effect as reset, but gated by en).
  - 111 reserved: behaves as HOLD.
- Count and flags
  - Count saturates at DEPTH; no wrap.
  - full is asserted combinationally from count.
  - A shift at full still shifts data; count stays DEPTH.
- Read port
  - rd_addr >= DEPTH (non-power-of-2 DEPTH only): rd_data = 0.
  - Same-cycle read of an entry being written returns the old value; there is no bypass.
- Simultaneous events
  - Reset asserted together with any en/op: reset wins, and the op is lost.
  - Reset asserted mid-sequence (e.g. during a rotation run): the next cycle shows the cleared state, and the sequence does not resume.
- Structure
  - Two-segment style: a state register block, plus a combinational next-state block using blocking assignments with a default of hold.

Test Plan:
- W=4, DEPTH=4. Reset, then SHU with d=1,2,3 over three cycles. Required: q_head=3, r[1]=2, r[2]=1, q_tail=0, count=3, full=0. One more SHU with d=4: q_tail=1, count=4, full=1.
- Continuing from full, SHU d=5 then d=6. Required: q_head=6, q_tail=3, count stays 4, full=1.
- Starting from {r0..r3}={6,5,4,3}: ROU gives {3,6,5,4}, then ROD gives {6,5,4,3}; count unchanged at 4. With en=0 and op=ROU for 3 cycles: no change.
- LOAD wr_addr=2, d=A. Same-cycle rd_addr=2 returns the old value 4; next cycle rd_data=A. DEPTH=6 bench: LOAD to wr_addr=7 writes nothing, and rd_addr=7 reads 0.
- SHD d=9 on {6,5,A,3}. Required: {5,A,3,9}. Then CLR with en=1: all 0, count=0. Repeat CLR with en=0: no effect.
- Assert reset in the same cycle as SHU d=F while count=2. Required: next cycle all entries 0, count=0, and F is not stored.
